// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: walks the program counter through memory, assembles
// one- or two-byte instructions and hands them to execute; jumps redirect the counter.
module fetch_sequencer #(
  parameter int OPERAND_BIT = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [7:0] pc_load_val,
  output logic [7:0] mem_addr,
  output logic       mem_req,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_operand,
  output logic       instr_two_byte,
  output logic [7:0] instr_pc,
  input  logic       jump_req,
  input  logic [7:0] jump_target
);

  typedef enum logic [1:0] {START, OP, ARG, HOLD} state_t;

  state_t     state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] instr_pc_q, instr_pc_d;
  logic       jump_active;
  logic       accept;

  // A jump is honoured everywhere except the single START cycle after reset.
  assign jump_active = jump_req && (state_q != START);
  assign accept      = mem_req && mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= START;
      opcode_q   <= 8'h00;
      operand_q  <= 8'h00;
      instr_pc_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    instr_pc_d = instr_pc_q;
    if (jump_active) begin
      state_d = OP;
    end else begin
      unique case (state_q)
        START: state_d = OP;
        OP: begin
          if (accept) begin
            opcode_d   = mem_rdata;
            instr_pc_d = pc;
            operand_d  = 8'h00;
            state_d    = mem_rdata[OPERAND_BIT] ? ARG : HOLD;
          end
        end
        ARG: begin
          if (accept) begin
            operand_d = mem_rdata;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) state_d = OP;
        end
        default: state_d = START;
      endcase
    end
  end

  // mem_req is masked by the raw jump_req; START never requests, so no gating is needed there.
  always_comb begin
    mem_req        = ((state_q == OP) || (state_q == ARG)) && !jump_req;
    pc_inc         = mem_req && mem_ack;
    pc_load        = jump_active;
    pc_load_val    = jump_target;
    mem_addr       = pc;
    instr_valid    = (state_q == HOLD);
    instr_opcode   = opcode_q;
    instr_operand  = operand_q;
    instr_two_byte = opcode_q[OPERAND_BIT];
    instr_pc       = instr_pc_q;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller that sits directly upstream of the 8-bit program counter: it consumes the counter's current value as the fetch address, reads one- and two-byte instructions from memory over a req/ack handshake, and drives the counter's increment and load controls. Fetched instructions are handed to the execute stage through a valid/ready handshake. Jump requests from execute redirect the counter and abort any fetch in progress.

## Interface

Parameters:
- `OPERAND_BIT`, default 7. Opcode bit that, when 1, marks a two-byte instruction (opcode followed by an operand byte).

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pc`  in  8  current program counter value (counter `out`).
- `pc_inc`  out  1  counter increment enable (counter `enable`).
- `pc_load`  out  1  counter load select (counter `sel_in`).
- `pc_load_val`  out  8  counter load value (counter `in`).
- `mem_addr`  out  8  memory read address.
- `mem_req`  out  1  memory read request.
- `mem_ack`  in  1  read data valid; meaningful only while `mem_req`=1.
- `mem_rdata`  in  8  read data, valid with `mem_ack`.
- `instr_valid`  out  1  instruction available to execute.
- `instr_ready`  in  1  execute accepts the instruction.
- `instr_opcode`  out  8  latched opcode.
- `instr_operand`  out  8  latched operand; 0 for one-byte instructions.
- `instr_two_byte`  out  1  latched `opcode[OPERAND_BIT]`.
- `instr_pc`  out  8  address the opcode was fetched from.
- `jump_req`  in  1  redirect request from execute.
- `jump_target`  in  8  redirect address.

The counter's `down` input is tied to 0 by the parent; this block never decrements.

## Operation

- States: START, OP, ARG, HOLD.
- START (reset state): all requests low; next state is OP unconditionally.
- OP: `mem_req`=1, `mem_addr`=`pc`. On `mem_ack`: latch `opcode`<=`mem_rdata`, `instr_pc`<=`pc`, `operand`<=0; `pc_inc`=1 this cycle. Go to ARG if `mem_rdata[OPERAND_BIT]`, else HOLD. With no ack, remain in OP.
- ARG: `mem_req`=1, `mem_addr`=`pc` (already incremented). On `mem_ack`: latch `operand`<=`mem_rdata`; `pc_inc`=1; go to HOLD.
- HOLD: `instr_valid`=1 and instruction outputs stable. On `instr_ready`: go to OP.
- `pc_inc` = `mem_req` & `mem_ack` & state in {OP, ARG} & ~`jump_req`. Combinational, one cycle per accepted byte.
- Jump, in any state except START:
  - `pc_load`=`jump_req` and `pc_load_val`=`jump_target`, combinational.
  - `mem_req` is forced to 0 that cycle.
  - Any ack in the same cycle is ignored: no latch, no `pc_inc`.
  - Next state is OP.
  - In HOLD, a same-cycle `instr_ready` still counts as consumption, and `instr_valid` stays 1 that cycle.
- Memory protocol: at most one request outstanding. Dropping `mem_req` without an ack cancels the request. Memory may ack in the same cycle as the request or any later cycle.
- Address arithmetic is 8-bit modulo; fetch proceeds normally across 0xFF→0x00 wrap (counter wraps).
- `pc_inc` and `pc_load` are never both 1.

## Timing

- Reset values (async): state=START. Outputs: `mem_req`=0, `pc_inc`=0, `pc_load`=0, `instr_valid`=0, `instr_opcode`=0, `instr_operand`=0, `instr_two_byte`=0, `instr_pc`=0, `mem_addr`=`pc`, `pc_load_val`=`jump_target`.
- First `mem_req` appears in the second cycle after reset deassertion (START occupies one cycle).
- With memory acking in the request cycle:
  - One-byte instruction: OP→HOLD, `instr_valid` one cycle after the ack.
  - Two-byte instruction: OP→ARG→HOLD, `instr_valid` two cycles after the opcode ack.
- Throughput with zero-wait memory and `instr_ready` held 1:
  - One-byte instructions: one instruction per 2 cycles.
  - Two-byte instructions: one instruction per 3 cycles.
- After a jump cycle, `pc` equals the target, and the OP request in the next cycle uses it.
- Reset mid-operation returns to START immediately and discards latched instruction state.

## Test plan

- Reset, memory acks every request, mem[0x00]=0x12, `instr_ready`=1 → `mem_req` first high in cycle 2 at addr 0x00; `instr_valid` with opcode 0x12, operand 0x00, `instr_pc`=0x00; `pc`=0x01.
- mem[0x05]=0x83, mem[0x06]=0x44, start pc=0x05 → requests at 0x05 then 0x06; `pc_inc` pulses twice; instruction 0x83/0x44, `instr_two_byte`=1, `instr_pc`=0x05; `pc`=0x07.
- `instr_ready`=0 for 4 cycles in HOLD → `instr_valid` and all instruction fields stable; no `mem_req`; `pc` unchanged; fetch resumes the cycle after `instr_ready`=1.
- `jump_req`=1 with target 0x40 in the same cycle as the ARG ack → operand not latched, `pc_inc`=0, `pc_load`=1; next cycle OP requests 0x40.
- Memory with 3 wait cycles, then `reset` asserted during the wait → all outputs at reset values; after release, fetch restarts from `pc`=0x00.
- pc=0xFF, mem[0xFF]=0x90, mem[0x00]=0x11 → operand fetched from 0x00, instruction 0x90/0x11, `pc`=0x01.
